ex_muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers, instantiated in the EX stage beside the ALU. It executes signed and unsigned MULT/DIV and MTHI/MTLO. It is parametrised in operand width. Multi-cycle operation is exposed through a busy/stall handshake to the hazard controller, and an in-flight operation can be cancelled by a pipeline flush.

---
 rtl/ex_muldiv_unit_if.sv | 30 +++
 rtl/ex_muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// Purpose: bundles the EX-stage request, hazard and HI/LO result signals of the mul/div unit.
// Ports:   master = pipeline side (drives start/func/operands/flush/reads),
//          slave  = ex_muldiv_unit (drives busy/stall_req/done/hi/lo).
interface ex_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       func;
    logic             is_sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             read_hi;
    logic             read_lo;
    logic             busy;
    logic             stall_req;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, func, is_sign, a, b, flush, read_hi, read_lo,
        input  busy, stall_req, done, hi, lo
    );

    modport slave (
        input  start, func, is_sign, a, b, flush, read_hi, read_lo,
        output busy, stall_req, done, hi, lo
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Purpose: iterative MULT/DIV (signed/unsigned) plus MTHI/MTLO with architectural HI/LO registers.
// Ports:   clk, rst (async, active-high), bus = ex_muldiv_unit_if.slave.
// Timing:  accept edge 0, WIDTH RUN edges, sign-fix commit at edge WIDTH+1; busy stalls only HI/LO users.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    ex_muldiv_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] FUNC_MULT = 3'd1;
    localparam logic [2:0] FUNC_DIV  = 3'd2;
    localparam logic [2:0] FUNC_MTHI = 3'd3;
    localparam logic [2:0] FUNC_MTLO = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_div_q, op_div_d;
    logic               neg_res_q, neg_res_d;   // negate product / quotient in FIX
    logic               neg_rem_q, neg_rem_d;   // negate remainder in FIX
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;         // |b|: multiplicand or divisor
    logic [WIDTH-1:0]   acc_q, acc_d;           // product high half / partial remainder
    logic [WIDTH-1:0]   quo_q, quo_d;           // multiplier bits / dividend->quotient
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand conditioning for accept
    logic               a_neg, b_neg, div_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;

    // One iteration of each algorithm
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;

    // Sign-fixed results
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        a_neg    = bus.is_sign && bus.a[WIDTH-1];
        b_neg    = bus.is_sign && bus.b[WIDTH-1];
        a_mag    = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
        b_mag    = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
        div_zero = (bus.func == FUNC_DIV) && (bus.b == '0);

        // Shift-add: add multiplicand when the current multiplier LSB is set, then shift right.
        mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, dvsr_q} : '0);
        // Restoring: bring in next dividend bit, subtract if it fits.
        div_shift = {acc_q, quo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, dvsr_q};
        div_diff  = div_shift[WIDTH-1:0] - dvsr_q;

        prod     = {acc_q, quo_q};
        prod_fix = neg_res_q ? (~prod + (2*WIDTH)'(1)) : prod;
        quo_fix  = neg_res_q ? (~quo_q + WIDTH'(1)) : quo_q;
        rem_fix  = neg_rem_q ? (~acc_q + WIDTH'(1)) : acc_q;

        state_d   = state_q;
        cnt_d     = cnt_q;
        op_div_d  = op_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dvsr_d    = dvsr_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.func)
                        FUNC_MULT, FUNC_DIV: begin
                            op_div_d = (bus.func == FUNC_DIV);
                            acc_d    = '0;
                            // Divide by zero: run the raw dividend through with no sign fix,
                            // so the algorithm leaves quotient=all ones, remainder=a.
                            quo_d     = div_zero ? bus.a : a_mag;
                            dvsr_d    = b_mag;
                            neg_res_d = !div_zero && (a_neg ^ b_neg);
                            neg_rem_d = !div_zero && (bus.func == FUNC_DIV) && a_neg;
                            cnt_d     = CNT_W'(WIDTH - 1);
                            state_d   = ST_RUN;
                        end
                        FUNC_MTHI: hi_d = bus.a;
                        FUNC_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (op_div_q) begin
                        acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], div_ge};
                    end else begin
                        acc_d = mul_sum[WIDTH:1];
                        quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (op_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dvsr_q    <= '0;
            acc_q     <= '0;
            quo_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_div_q  <= op_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dvsr_q    <= dvsr_d;
            acc_q     <= acc_d;
            quo_q     <= quo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    // Only instructions that touch HI/LO or issue to the unit wait for it.
    assign bus.stall_req = bus.busy && (bus.start || bus.read_hi || bus.read_lo);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.WIDTH(W)) bus ();

    ex_muldiv_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0]  exp_q[$];
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural definition. Returns {hi, lo}.
    function automatic logic [63:0] ref_op(input logic [2:0] f, input bit sgn,
                                           input logic [31:0] x, input logic [31:0] y);
        longint p;
        int q, r;
        if (f == 3'd1) begin
            if (sgn) begin
                p = longint'($signed(x)) * longint'($signed(y));
                return p;
            end
            return {32'h0, x} * {32'h0, y};
        end
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (sgn) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
            return {r, q};
        end
        return {x % y, x / y};
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", bus.done, 1'b0);
            end else begin
                chk("result_hi_lo", {bus.hi, bus.lo}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [2:0] f, input bit s, input logic [31:0] x, input logic [31:0] y);
        bus.func = f; bus.is_sign = s; bus.a = x; bus.b = y; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.func = 3'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_wait", bus.busy, 1'b0);
    endtask

    task automatic expect_op(input logic [2:0] f, input bit s, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] e;
        e = ref_op(f, s, x, y);
        exp_q.push_back(e);
        {model_hi, model_lo} = e;
    endtask

    task automatic run_op(input logic [2:0] f, input bit s, input logic [31:0] x, input logic [31:0] y);
        int lat = 0;
        wait_idle();
        expect_op(f, s, x, y);
        issue(f, s, x, y);
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, W + 1);
        chk("busy_at_done", bus.busy, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", bus.done, 1'b0);
    endtask

    task automatic mt(input logic [2:0] f, input logic [31:0] x);
        wait_idle();
        issue(f, 1'b0, x, 32'h0);
        if (f == 3'd3) model_hi = x; else model_lo = x;
        chk("mt_hi", bus.hi, model_hi);
        chk("mt_lo", bus.lo, model_lo);
        chk("mt_busy", bus.busy, 1'b0);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int stall_cnt;
        bit seen;
        rst = 1'b1;
        bus.start = 1'b0; bus.func = 3'd0; bus.is_sign = 1'b0;
        bus.a = '0; bus.b = '0; bus.flush = 1'b0; bus.read_hi = 1'b0; bus.read_lo = 1'b0;
        #12;
        chk("reset_hi", bus.hi, 32'h0);
        chk("reset_lo", bus.lo, 32'h0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_done", bus.done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed arithmetic cases
        run_op(3'd1, 1'b1, 32'hFFFF_FFFD, 32'h5);
        run_op(3'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd2, 1'b1, 32'hFFFF_FFF9, 32'h2);
        run_op(3'd2, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd2, 1'b0, 32'h1234_5678, 32'h0);
        run_op(3'd2, 1'b1, 32'hF234_5678, 32'h0);
        run_op(3'd2, 1'b0, 32'hFFFF_FFF9, 32'h2);

        // Hazard: MFLO behind a MULT stalls until the done cycle, then reads the new LO
        wait_idle();
        expect_op(3'd1, 1'b0, 32'h0001_0003, 32'h0002_0007);
        issue(3'd1, 1'b0, 32'h0001_0003, 32'h0002_0007);
        @(posedge clk); #1;
        bus.read_lo = 1'b1;
        stall_cnt = 0; seen = 1'b0;
        for (int k = 0; k < W + 8 && !seen; k++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                chk("stall_in_done_cycle", bus.stall_req, 1'b0);
                chk("lo_in_done_cycle", bus.lo, model_lo);
            end else if (bus.stall_req) begin
                stall_cnt++;
            end
        end
        bus.read_lo = 1'b0;
        chk("hazard_done_seen", seen, 1'b1);
        chk("stall_cycles", stall_cnt, W);

        // Unrelated instruction, MFHI and a second start while busy
        wait_idle();
        expect_op(3'd2, 1'b0, 32'd1000, 32'd7);
        issue(3'd2, 1'b0, 32'd1000, 32'd7);
        repeat (5) begin @(posedge clk); #1; end
        chk("unrelated_busy", bus.busy, 1'b1);
        chk("unrelated_no_stall", bus.stall_req, 1'b0);
        bus.read_hi = 1'b1; #1;
        chk("mfhi_stall", bus.stall_req, 1'b1);
        bus.read_hi = 1'b0;
        bus.func = 3'd1; bus.a = 32'd3; bus.b = 32'd3; bus.start = 1'b1; #1;
        chk("start_busy_stall", bus.stall_req, 1'b1);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.func = 3'd0;
        repeat (80) begin @(posedge clk); #1; end
        chk("no_queued_start", bus.busy, 1'b0);

        // Reset in RUN cycle 10
        wait_idle();
        issue(3'd1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) begin @(posedge clk); #1; end
        chk("pre_reset_busy", bus.busy, 1'b1);
        rst = 1'b1; #1;
        chk("midreset_busy", bus.busy, 1'b0);
        chk("midreset_hi", bus.hi, 32'h0);
        chk("midreset_lo", bus.lo, 32'h0);
        model_hi = '0; model_lo = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        chk("postreset_busy", bus.busy, 1'b0);
        chk("postreset_hilo", {bus.hi, bus.lo}, 64'h0);

        // Flush in RUN cycle 20
        mt(3'd3, 32'hA5A5_A5A5);
        mt(3'd4, 32'hA5A5_A5A5);
        issue(3'd2, 1'b0, 32'd100, 32'd7);
        repeat (19) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_run_busy", bus.busy, 1'b0);
        repeat (40) begin @(posedge clk); #1; end
        chk("flush_run_hilo", {bus.hi, bus.lo}, {model_hi, model_lo});

        // Flush on the FIX commit edge
        issue(3'd1, 1'b0, 32'd9, 32'd9);
        repeat (W) begin @(posedge clk); #1; end
        chk("fix_busy", bus.busy, 1'b1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_fix_busy", bus.busy, 1'b0);
        chk("flush_fix_done", bus.done, 1'b0);
        chk("flush_fix_hilo", {bus.hi, bus.lo}, {model_hi, model_lo});

        // Flush with start in IDLE, MTHI under flush, reserved funcs
        bus.flush = 1'b1;
        issue(3'd2, 1'b0, 32'd50, 32'd5);
        chk("flush_start_busy", bus.busy, 1'b0);
        issue(3'd3, 1'b0, 32'hDEAD_BEEF, 32'h0);
        bus.flush = 1'b0;
        chk("flush_mthi_hi", bus.hi, model_hi);
        for (int f = 5; f < 8; f++) begin
            issue(3'(f), 1'b0, 32'h1111_2222, 32'h3);
            chk("reserved_busy", bus.busy, 1'b0);
            chk("reserved_hilo", {bus.hi, bus.lo}, {model_hi, model_lo});
        end
        mt(3'd3, 32'h5);

        // Randomized mix
        for (int i = 0; i < 120; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) mt(3'd3, $urandom());
            else if (sel == 1) mt(3'd4, $urandom());
            else run_op((sel < 6) ? 3'd1 : 3'd2, bit'($urandom_range(0, 1)), rand_opnd(), rand_opnd());
        end

        repeat (3) begin @(posedge clk); #1; end
        chk("pending_results", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
